// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the request/ack interface.
// A request accepted in IDLE waits LATENCY cycles, performs one read or write,
// then pulses ack for a single cycle. Only one transaction is in flight at a time.
// Reset reloads every word with its own index so tests start from a known pattern.
module mem_responder #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;

   // The wait counter is 4 bits wide, which bounds LATENCY to 1..15.
   if (LATENCY < 1 || LATENCY > 15) begin : g_latency_illegal
      $error("mem_responder: LATENCY must be within 1..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [3:0]        cnt_r;
   logic [3:0]        cnt_nxt_s;
   logic              capture_s;
   logic              do_op_s;
   logic              ack_nxt_s;
   logic              busy_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic              we_r;
   logic [DATA_W-1:0] wdata_r;
   logic              ack_r;
   logic              busy_r;
   logic [DATA_W-1:0] rdata_r;
   logic [DATA_W-1:0] mem_r [DEPTH];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode: accept in IDLE, count down in WAIT, one cycle in ACK.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_ACK;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_ACK:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode: capture strobe, counter update, operation strobe and next output values.
   always_comb begin
      capture_s  = 1'b0;
      do_op_s    = 1'b0;
      cnt_nxt_s  = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               capture_s = 1'b1;
               cnt_nxt_s = 4'(LATENCY - 1);
            end else begin
               capture_s = 1'b0;
               cnt_nxt_s = cnt_r;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 4'd0) begin
               do_op_s   = 1'b1;
               cnt_nxt_s = 4'd0;
            end else begin
               do_op_s   = 1'b0;
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         ST_ACK:  cnt_nxt_s = cnt_r;
         default: cnt_nxt_s = 4'd0;
      endcase
      // Outputs are registered from the next state so they align with the state register.
      ack_nxt_s  = (state_nxt_s == ST_ACK);
      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // Request capture, wait counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r   <= 4'd0;
         addr_r  <= '0;
         we_r    <= 1'b0;
         wdata_r <= '0;
         ack_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         ack_r  <= ack_nxt_s;
         busy_r <= busy_nxt_s;
         if (capture_s) begin
            addr_r  <= addr;
            we_r    <= we;
            wdata_r <= wdata;
         end
      end
   end

   // Memory array and read-data register; reset restores the index pattern and aborts any write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= DATA_W'(i);
         end
      end else if (do_op_s) begin
         if (we_r) begin
            mem_r[addr_r] <= wdata_r;
         end else begin
            rdata_r <= mem_r[addr_r];
         end
      end
   end

   assign ack   = ack_r;
   assign busy  = busy_r;
   assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 main instance,
// plus a LATENCY=1 instance sharing the same stimulus).
module tb_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;
   logic        ack1;
   logic [31:0] rdata1;
   logic        busy1;

   int n_cmp = 0;
   int n_bad = 0;

   mem_responder #(.ADDR_W(4), .DATA_W(32), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy)
   );

   mem_responder #(.ADDR_W(4), .DATA_W(32), .LATENCY(1)) dut_lat1 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ack(ack1), .rdata(rdata1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one transaction on the main instance; lat counts negedges after capture until ack (-1 on timeout).
   task automatic run_txn(input logic t_we, input logic [3:0] t_addr, input logic [31:0] t_wdata,
                          output int lat, output logic [31:0] rd);
      int n;
      @(negedge clk);
      req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
      @(negedge clk);
      req = 1'b0;
      n = 1;
      while (ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      lat = (ack === 1'b1) ? n : -1;
      rd  = rdata;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0;
      @(negedge clk);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read_latency();
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 4'd5;
      @(negedge clk); // after capture edge k
      req = 1'b0;
      n_cmp++; if (busy !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL rd5_k busy=%b ack=%b want 1/0", busy, ack); end
      @(negedge clk); // after k+1
      n_cmp++; if (busy !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL rd5_k1 busy=%b ack=%b want 1/0", busy, ack); end
      @(negedge clk); // after k+2
      n_cmp++; if (busy !== 1'b1 || ack !== 1'b1) begin n_bad++; $display("FAIL rd5_k2 busy=%b ack=%b want 1/1", busy, ack); end
      n_cmp++; if (rdata !== 32'h0000_0005) begin n_bad++; $display("FAIL rd5_data got %h want 00000005", rdata); end
      @(negedge clk); // after k+3
      n_cmp++; if (busy !== 1'b0 || ack !== 1'b0) begin n_bad++; $display("FAIL rd5_k3 busy=%b ack=%b want 0/0", busy, ack); end
      n_cmp++; if (rdata !== 32'h0000_0005) begin n_bad++; $display("FAIL rd5_hold got %h want 00000005", rdata); end
   endtask

   task automatic test_write_read();
      int lat;
      logic [31:0] rd;
      run_txn(1'b1, 4'd15, 32'hDEAD_BEEF, lat, rd);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr15_lat got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'h0000_0005) begin n_bad++; $display("FAIL wr15_rdata_held got %h want 00000005", rd); end
      run_txn(1'b0, 4'd15, 32'd0, lat, rd);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd15_lat got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd15_data got %h want deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int last;
      apply_reset();
      cyc = 0; last = 0;
      req = 1'b1; we = 1'b0; addr = 4'd0;
      for (int i = 0; i < 16; i++) begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            cyc++; n++;
         end while (ack !== 1'b1 && n < 20);
         n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack[%0d] got %b want 1 (timeout)", i, ack); end
         n_cmp++; if (rdata !== 32'(i)) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, rdata, 32'(i)); end
         if (i > 0) begin
            n_cmp++; if (cyc - last !== 4) begin n_bad++; $display("FAIL b2b_spacing[%0d] got %0d want 4", i, cyc - last); end
         end
         last = cyc;
         addr = 4'(i + 1);
      end
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int lat;
      logic saw_ack;
      logic [31:0] rd;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'd3; wdata = 32'h0000_1234;
      @(negedge clk); // captured, now in WAIT
      req = 1'b0; we = 1'b0;
      rst_n = 1'b0;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ack === 1'b1) saw_ack = 1'b1;
         rst_n = 1'b1;
      end
      n_cmp++; if (saw_ack !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack got %b want 0", saw_ack); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
      run_txn(1'b0, 4'd3, 32'd0, lat, rd);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL abort_rd3_lat got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'h0000_0003) begin n_bad++; $display("FAIL abort_rd3_data got %h want 00000003", rd); end
   endtask

   task automatic test_ignore_inputs();
      int lat;
      int n;
      logic [31:0] rd;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 4'd7; wdata = 32'd0;
      @(negedge clk); // captured
      req = 1'b0; we = 1'b1; addr = 4'd9; wdata = 32'hFFFF_FFFF;
      n = 1;
      while (ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL ign_lat got %0d want 3", n); end
      n_cmp++; if (rdata !== 32'h0000_0007) begin n_bad++; $display("FAIL ign_rdata got %h want 00000007", rdata); end
      we = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 4'd9, 32'd0, lat, rd);
      n_cmp++; if (rd !== 32'h0000_0009) begin n_bad++; $display("FAIL ign_mem9 got %h want 00000009", rd); end
      run_txn(1'b0, 4'd7, 32'd0, lat, rd);
      n_cmp++; if (rd !== 32'h0000_0007) begin n_bad++; $display("FAIL ign_mem7 got %h want 00000007", rd); end
   endtask

   task automatic test_latency1();
      int n;
      apply_reset();
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 4'd2;
      @(negedge clk); // after capture edge k
      req = 1'b0;
      n_cmp++; if (busy1 !== 1'b1 || ack1 !== 1'b0) begin n_bad++; $display("FAIL lat1_k busy=%b ack=%b want 1/0", busy1, ack1); end
      n = 1;
      while (ack1 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL lat1_lat got %0d want 2", n); end
      n_cmp++; if (rdata1 !== 32'h0000_0002) begin n_bad++; $display("FAIL lat1_data got %h want 00000002", rdata1); end
      @(negedge clk);
      n_cmp++; if (busy1 !== 1'b0 || ack1 !== 1'b0) begin n_bad++; $display("FAIL lat1_done busy=%b ack=%b want 0/0", busy1, ack1); end
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0;
      test_reset();
      test_read_latency();
      test_write_read();
      test_back_to_back();
      test_reset_abort();
      test_ignore_inputs();
      test_latency1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
